// File: rtl/spram_arbiter_pkg.sv
// Shared encodings for the spram arbiter: FSM states and access-owner codes.
package spram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RMW_RD   = 3'd3,
    ST_RMW_WAIT = 3'd4,
    ST_WR       = 3'd5
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-requester arbiter (I vs D). Grants only while en is high; the pointer
// remembers which port gets preference on the next simultaneous request.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  logic prio_d;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (req_i && req_d) begin
        if (RR && !prio_d) gnt_i = 1'b1;
        else               gnt_d = 1'b1;
      end else begin
        gnt_i = req_i;
        gnt_d = req_d;
      end
    end
  end

  // After any grant, the other port is preferred next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             prio_d <= 1'b0;
    else if (gnt_i | gnt_d) prio_d <= gnt_i;
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port spram between an instruction-fetch port (I) and a
// load/store port (D); partial-strobe stores become read-modify-write.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 15,
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  // Handshake: a requester raises req with its command and holds both steady
  // until it sees a one-cycle ack; the command is latched at grant, so later
  // changes (including dropping req) do not affect the access in flight.
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [W-1:0]  i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [W-1:0]  d_wdata,
  input  logic [W/8-1:0] d_wstrb,
  output logic          d_ack,
  output logic [W-1:0]  d_rdata,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [W-1:0]  mem_wr_data,
  input  logic [W-1:0]  mem_rd_data,
  input  logic          mem_rd_valid,
  output logic [2:0]    dbg_state
);

  localparam int SW = W / 8;

  state_t        state, state_nx;
  owner_t        owner;
  logic          gnt_i, gnt_d, grant, rd_done;
  logic [W-1:0]  lat_wdata, merged, i_rdata_q, d_rdata_q;
  logic [SW-1:0] lat_wstrb;

  rr_arb2 #(.RR(RR)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_IDLE),
    .req_i (i_req),
    .req_d (d_req),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  assign grant     = gnt_i | gnt_d;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (gnt_i || (gnt_d && !d_we)) state_nx = ST_RD;
        else if (gnt_d) begin
          if (&d_wstrb)      state_nx = ST_WR;
          else if (|d_wstrb) state_nx = ST_RMW_RD;
          else               state_nx = ST_WR;
        end
      end
      ST_RD:       state_nx = ST_WAIT;
      ST_WAIT:     if (mem_rd_valid) state_nx = ST_IDLE;
      ST_RMW_RD:   state_nx = ST_RMW_WAIT;
      ST_RMW_WAIT: if (mem_rd_valid) state_nx = ST_WR;
      ST_WR:       state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Strobed bytes come from the store, the rest from the word just read.
  always_comb begin
    merged = mem_rd_data;
    for (int b = 0; b < SW; b++) begin
      if (lat_wstrb[b]) merged[8*b +: 8] = lat_wdata[8*b +: 8];
    end
  end

  // Enables are one-cycle pulses; address and write data hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= OWN_I;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      if (state == ST_IDLE && grant) begin
        owner     <= gnt_i ? OWN_I : OWN_D;
        mem_addr  <= gnt_i ? i_addr : d_addr;
        lat_wdata <= d_wdata;
        lat_wstrb <= d_wstrb;
        if (gnt_i || !d_we) begin
          mem_rd_en <= 1'b1;
        end else if (&d_wstrb) begin
          mem_wr_en   <= 1'b1;
          mem_wr_data <= d_wdata;
        end else if (|d_wstrb) begin
          mem_rd_en <= 1'b1;
        end
      end else if (state == ST_RMW_WAIT && mem_rd_valid) begin
        mem_wr_en   <= 1'b1;
        mem_wr_data <= merged;
      end
    end
  end

  assign rd_done = (state == ST_WAIT) && mem_rd_valid;
  assign i_ack   = rd_done && (owner == OWN_I);
  assign d_ack   = (rd_done && (owner == OWN_D)) || (state == ST_WR);
  assign i_rdata = i_ack ? mem_rd_data : i_rdata_q;
  assign d_rdata = (rd_done && (owner == OWN_D)) ? mem_rd_data : d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ack)                          i_rdata_q <= mem_rd_data;
      if (rd_done && (owner == OWN_D))    d_rdata_q <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: spram model, reference memory, expected-read queue.
module tb_spram_arbiter;
  import spram_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int AW = 15;
  localparam int SW = W / 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (round-robin) ----------------
  logic           i_req, i_ack, d_req, d_we, d_ack;
  logic [AW-1:0]  i_addr, d_addr, mem_addr;
  logic [W-1:0]   i_rdata, d_rdata, d_wdata, mem_wr_data, mem_rd_data;
  logic [SW-1:0]  d_wstrb;
  logic           mem_rd_en, mem_wr_en;
  logic           mem_rd_valid = 1'b0;
  logic [2:0]     dbg_state;

  spram_arbiter #(.W(W), .AW(AW), .RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT 1 (fixed priority) ----------------
  logic           f_i_req, f_i_ack, f_d_req, f_d_we, f_d_ack;
  logic [AW-1:0]  f_i_addr, f_d_addr, f_mem_addr;
  logic [W-1:0]   f_i_rdata, f_d_rdata, f_d_wdata, f_mem_wr_data, f_mem_rd_data;
  logic [SW-1:0]  f_d_wstrb;
  logic           f_mem_rd_en, f_mem_wr_en;
  logic           f_mem_rd_valid = 1'b0;
  logic [2:0]     f_dbg_state;

  spram_arbiter #(.W(W), .AW(AW), .RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req(f_i_req), .i_addr(f_i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata),
    .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata), .d_wstrb(f_d_wstrb),
    .d_ack(f_d_ack), .d_rdata(f_d_rdata),
    .mem_rd_en(f_mem_rd_en), .mem_addr(f_mem_addr), .mem_wr_en(f_mem_wr_en),
    .mem_wr_data(f_mem_wr_data), .mem_rd_data(f_mem_rd_data), .mem_rd_valid(f_mem_rd_valid),
    .dbg_state(f_dbg_state)
  );

  // ---------------- spram models ----------------
  logic [W-1:0] sram [256];
  logic         pre_we = 1'b0;
  logic [7:0]   pre_idx = '0;
  logic [W-1:0] pre_data = '0;

  always @(posedge clk) begin
    mem_rd_valid <= mem_rd_en;
    if (mem_rd_en) mem_rd_data <= sram[mem_addr[9:2]];
    if (mem_wr_en) sram[mem_addr[9:2]] <= mem_wr_data;
    else if (pre_we) sram[pre_idx] <= pre_data;
  end

  always @(posedge clk) begin
    f_mem_rd_valid <= f_mem_rd_en;
    f_mem_rd_data  <= 32'hF000_0000 | 32'(f_mem_addr);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] exp_q [$];
  logic         own_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = addr[9:2]; pre_data = data;
    ref_mem[addr[9:2]] = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns ack latency, first mem_rd_en
  // cycle and number of mem_wr_en cycles, all counted from the request cycle.
  task automatic do_access(input string tag, input logic port_d, input logic we,
                           input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                           input logic [SW-1:0] strb, output int lat, output int rd_cyc,
                           output int wr_cnt);
    logic own_ack, oth_ack;
    lat = -1; rd_cyc = -1; wr_cnt = 0;
    if (!we) exp_q.push_back(ref_mem[addr[9:2]]);
    else     ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, strb);
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      own_ack = port_d ? d_ack : i_ack;
      oth_ack = port_d ? i_ack : d_ack;
      check({tag, "_excl"}, {31'b0, mem_rd_en & mem_wr_en}, '0);
      check({tag, "_other_ack"}, {31'b0, oth_ack}, '0);
      if (mem_rd_en && rd_cyc < 0) rd_cyc = c;
      if (mem_wr_en) wr_cnt++;
      if (own_ack) begin
        lat = c;
        if (!we) begin
          if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
          else check({tag, "_rdata"}, port_d ? d_rdata : i_rdata, exp_q.pop_front());
        end
      end
      if (c == 1) begin
        // Scramble the command after grant: the DUT must use the latched copy.
        if (port_d) begin
          d_req = 1'b0; d_we = 1'($urandom_range(0, 1)); d_addr = AW'($urandom);
          d_wdata = $urandom; d_wstrb = SW'($urandom);
        end else begin
          i_req = 1'b0; i_addr = AW'($urandom);
        end
      end
    end
    if (lat < 0) begin
      check({tag, "_timeout"}, 1, 0);
      if (!we && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    check({tag, "_ack_pulse"}, {31'b0, port_d ? d_ack : i_ack}, '0);
  endtask

  // ---------------- main sequence ----------------
  int lat, rdc, wrc, n0, n1;
  logic [AW-1:0] ra;
  logic [W-1:0]  rd;
  logic [SW-1:0] rs;
  logic          e_own;
  logic [W-1:0]  e_dat;

  initial begin
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    f_i_req = 0; f_i_addr = '0; f_d_req = 0; f_d_we = 0; f_d_addr = '0; f_d_wdata = '0;
    f_d_wstrb = '0;

    preload(15'h0010, 32'hDEAD_BEEF);
    preload(15'h0040, 32'h1111_2222);
    preload(15'h0044, 32'h3333_4444);
    preload(15'h0050, 32'h5A5A_C3C3);
    preload(15'h0060, 32'h0BAD_F00D);

    // Reset state
    check("rst_state", {29'b0, dbg_state}, '0);
    check("rst_acks", {30'b0, i_ack, d_ack}, '0);
    check("rst_mem_en", {30'b0, mem_rd_en, mem_wr_en}, '0);
    check("rst_mem_addr", {17'b0, mem_addr}, '0);
    check("rst_mem_wdata", mem_wr_data, '0);
    check("rst_rdata", i_rdata | d_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: lone I read
    do_access("t1", 1'b0, 1'b0, 15'h0010, '0, '0, lat, rdc, wrc);
    check("t1_lat", lat, 2);
    check("t1_rd_cyc", rdc, 1);

    // 2: full D write, then readbacks on both ports
    do_access("t2w", 1'b1, 1'b1, 15'h0020, 32'h1234_5678, 4'hF, lat, rdc, wrc);
    check("t2_lat", lat, 1);
    check("t2_wr_cnt", wrc, 1);
    check("t2_no_rd", rdc, -1);
    do_access("t2rd", 1'b1, 1'b0, 15'h0020, '0, '0, lat, rdc, wrc);
    check("t2rd_lat", lat, 2);
    do_access("t2ri", 1'b0, 1'b0, 15'h0020, '0, '0, lat, rdc, wrc);

    // 3: byte store as read-modify-write
    do_access("t3w", 1'b1, 1'b1, 15'h0030, 32'hAABB_CCDD, 4'hF, lat, rdc, wrc);
    do_access("t3p", 1'b1, 1'b1, 15'h0030, 32'h0000_1100, 4'b0010, lat, rdc, wrc);
    check("t3_lat", lat, 3);
    check("t3_rd_cyc", rdc, 1);
    check("t3_wr_cnt", wrc, 1);
    exp_q.push_back(32'hAABB_11DD);
    void'(exp_q.size());
    do_access("t3r", 1'b0, 1'b0, 15'h0030, '0, '0, lat, rdc, wrc);
    // Literal check against the known merge result (queued value above).
    if (exp_q.size() == 0) check("t3_sb_left", 1, 0);
    else check("t3_const", i_rdata, exp_q.pop_front());

    // Random full + partial stores with readback
    for (int k = 0; k < 5; k++) begin
      ra = AW'(15'h0100 + 4 * $urandom_range(0, 15));
      rd = $urandom;
      rs = SW'($urandom_range(1, 14));
      do_access("rnd_full", 1'b1, 1'b1, ra, $urandom, 4'hF, lat, rdc, wrc);
      do_access("rnd_part", 1'b1, 1'b1, ra, rd, rs, lat, rdc, wrc);
      check("rnd_part_lat", lat, 3);
      do_access("rnd_rb", 1'($urandom_range(0, 1)), 1'b0, ra, '0, '0, lat, rdc, wrc);
    end

    // 5: zero-strobe write is a no-op that still acks
    do_access("t5w", 1'b1, 1'b1, 15'h0060, 32'hFFFF_FFFF, 4'h0, lat, rdc, wrc);
    check("t5_lat", lat, 1);
    check("t5_wr_cnt", wrc, 0);
    do_access("t5r", 1'b1, 1'b0, 15'h0060, '0, '0, lat, rdc, wrc);

    // 6: reset during RMW_WAIT abandons the store
    d_req = 1'b1; d_we = 1'b1; d_addr = 15'h0050; d_wdata = 32'h00EE_0000; d_wstrb = 4'b0100;
    @(negedge clk);
    check("t6_rmw_rd", {29'b0, dbg_state}, 32'(ST_RMW_RD));
    d_req = 1'b0;
    @(negedge clk);
    check("t6_rmw_wait", {29'b0, dbg_state}, 32'(ST_RMW_WAIT));
    rst_n = 1'b0;
    #1;
    check("t6_state", {29'b0, dbg_state}, '0);
    check("t6_en", {30'b0, mem_rd_en, mem_wr_en}, '0);
    check("t6_acks", {30'b0, i_ack, d_ack}, '0);
    check("t6_addr", {17'b0, mem_addr}, '0);
    check("t6_wdata", mem_wr_data, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6_no_wr", {31'b0, mem_wr_en}, '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_access("t6r", 1'b1, 1'b0, 15'h0050, '0, '0, lat, rdc, wrc);
    check("t6r_lat", lat, 2);

    // 4: contention; RR alternates I,D,... while fixed priority always picks D
    for (int k = 0; k < 6; k++) begin
      own_q.push_back(k[0]);
      exp_q.push_back(k[0] ? ref_mem[17] : ref_mem[16]);
    end
    i_req = 1; d_req = 1; d_we = 0; i_addr = 15'h0040; d_addr = 15'h0044;
    f_i_req = 1; f_d_req = 1; f_d_we = 0; f_i_addr = 15'h0040; f_d_addr = 15'h0044;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 80 && (n0 < 6 || n1 < 6); c++) begin
      @(negedge clk);
      check("t4_excl", {31'b0, mem_rd_en & mem_wr_en}, '0);
      check("t4_fp_i_ack", {31'b0, f_i_ack}, '0);
      if (i_ack | d_ack) begin
        if (own_q.size() == 0) check("t4_extra_ack", 1, 0);
        else begin
          e_own = own_q.pop_front();
          e_dat = exp_q.pop_front();
          check("t4_rr_owner", {31'b0, d_ack}, {31'b0, e_own});
          check("t4_rr_both", {31'b0, i_ack & d_ack}, '0);
          check("t4_rr_rdata", d_ack ? d_rdata : i_rdata, e_dat);
        end
        n0++;
        if (n0 == 6) begin i_req = 0; d_req = 0; end
      end
      if (f_d_ack) begin
        check("t4_fp_rdata", f_d_rdata, 32'hF000_0044);
        n1++;
        if (n1 == 6) begin f_i_req = 0; f_d_req = 0; end
      end
    end
    i_req = 0; d_req = 0; f_i_req = 0; f_d_req = 0;
    check("t4_rr_count", n0, 6);
    check("t4_fp_count", n1, 6);
    @(negedge clk);
    @(negedge clk);
    check("t4_i_rdata_hold", i_rdata, 32'h1111_2222);
    check("t4_fp_i_rdata_idle", f_i_rdata, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
